// File: rtl/mem_write_arbiter.sv
// Two-requester write-port arbiter with burst grant, bounded hold and a registered memory-side stage.
// Optional per-requester transfer counters are enabled with `define ARB_STATS_EN.
module mem_write_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    output logic [ADDR_WIDTH-1:0] mem_in_addr,
    output logic [DATA_WIDTH-1:0] mem_in_data,
    output logic                  mem_in_valid,
    input  logic                  mem_in_ready,
    output logic [1:0]            grant,
    output logic                  busy
`ifdef ARB_STATS_EN
   ,output logic [15:0]           stat0_count,
    output logic [15:0]           stat1_count
`endif
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                  last_owner_q, last_owner_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  hs0, hs1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state logic: a grant ends when its owner goes idle or when the hold limit
    // is reached while the other side is waiting (direct hand-over, no IDLE cycle).
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = last_owner_q ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!req0_valid) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                    hold_cnt_d   = '0;
                end else if (hs0) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        if (req1_valid) begin
                            state_d      = GRANT1;
                            last_owner_d = 1'b0;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            GRANT1: begin
                if (!req1_valid) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                    hold_cnt_d   = '0;
                end else if (hs1) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        if (req0_valid) begin
                            state_d      = GRANT0;
                            last_owner_d = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Output logic: only the owner sees ready, and only when the output stage can take a word
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = 2'b00;
        case (state_q)
            GRANT0: begin
                req0_ready = !mem_valid_q || mem_in_ready;
                grant      = 2'b01;
            end
            GRANT1: begin
                req1_ready = !mem_valid_q || mem_in_ready;
                grant      = 2'b10;
            end
            default: ;
        endcase
    end

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;

    // A new load wins over the clear caused by a memory-side handshake on the same edge
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_valid_d = mem_valid_q;
        if (hs0) begin
            mem_addr_d  = req0_addr;
            mem_data_d  = req0_data;
            mem_valid_d = 1'b1;
        end else if (hs1) begin
            mem_addr_d  = req1_addr;
            mem_data_d  = req1_data;
            mem_valid_d = 1'b1;
        end else if (mem_in_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign mem_in_valid = mem_valid_q;
    assign mem_in_addr  = mem_addr_q;
    assign mem_in_data  = mem_data_q;
    assign busy         = (state_q != IDLE) || mem_valid_q;

`ifdef ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        stat0_d = hs0 ? sat_inc16(stat0_q) : stat0_q;
        stat1_d = hs1 ? sat_inc16(stat1_q) : stat1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_count = stat0_q;
    assign stat1_count = stat1_q;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Self-checking bench for mem_write_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_write_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_HOLD = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          v0, v1;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] mem_in_addr;
    logic [DW-1:0] mem_in_data;
    logic          mem_in_valid;
    logic          mr;
    logic [1:0]    grant;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [15:0]   stat0_count, stat1_count;
`endif

    mem_write_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_addr    (a0),
        .req0_data    (d0),
        .req0_valid   (v0),
        .req0_ready   (req0_ready),
        .req1_addr    (a1),
        .req1_data    (d1),
        .req1_valid   (v1),
        .req1_ready   (req1_ready),
        .mem_in_addr  (mem_in_addr),
        .mem_in_data  (mem_in_data),
        .mem_in_valid (mem_in_valid),
        .mem_in_ready (mr),
        .grant        (grant),
        .busy         (busy)
`ifdef ARB_STATS_EN
       ,.stat0_count  (stat0_count),
        .stat1_count  (stat1_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the port, how many words in the current streak,
    // who last gave it up, and the single word waiting at the memory side.
    int            m_owner;
    int            m_cnt;
    int            m_last;
    logic          m_ov;
    logic [AW-1:0] m_oa;
    logic [DW-1:0] m_od;
    int            m_st0, m_st1;
    logic          m_acc0, m_acc1;

    // Requester behaviour: words left in each burst
    int   left0, left1;
    logic obs_r1;
    logic obs_hs0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_ov    = 1'b0;
        m_oa    = '0;
        m_od    = '0;
        m_st0   = 0;
        m_st1   = 0;
        m_acc0  = 1'b0;
        m_acc1  = 1'b0;
    endtask

    task automatic model_edge();
        logic own_v, oth_v;
        m_acc0 = (m_owner == 0) && v0 && (!m_ov || mr);
        m_acc1 = (m_owner == 1) && v1 && (!m_ov || mr);
        if (m_acc0) begin
            m_ov = 1'b1; m_oa = a0; m_od = d0;
            if (m_st0 < 65535) m_st0++;
        end else if (m_acc1) begin
            m_ov = 1'b1; m_oa = a1; m_od = d1;
            if (m_st1 < 65535) m_st1++;
        end else if (mr) begin
            m_ov = 1'b0;
        end
        own_v = (m_owner == 0) ? v0 : v1;
        oth_v = (m_owner == 0) ? v1 : v0;
        if (m_owner < 0) begin
            m_cnt = 0;
            if (v0 && v1)  m_owner = 1 - m_last;
            else if (v0)   m_owner = 0;
            else if (v1)   m_owner = 1;
        end else if (!own_v) begin
            m_last  = m_owner;
            m_owner = -1;
            m_cnt   = 0;
        end else if (m_acc0 || m_acc1) begin
            m_cnt++;
            if (m_cnt == MAX_HOLD) begin
                m_cnt = 0;
                if (oth_v) begin
                    m_last  = m_owner;
                    m_owner = 1 - m_owner;
                end
            end
        end
    endtask

    // One clock cycle: drive valids, compare every output with the model, take the edge
    task automatic cycle();
        logic [1:0] eg;
        v0 = (left0 > 0);
        v1 = (left1 > 0);
        #1;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        check("grant", 64'(grant), 64'(eg));
        check("req0_ready", 64'(req0_ready), 64'((m_owner == 0) && (!m_ov || mr)));
        check("req1_ready", 64'(req1_ready), 64'((m_owner == 1) && (!m_ov || mr)));
        check("mem_in_valid", 64'(mem_in_valid), 64'(m_ov));
        check("busy", 64'(busy), 64'((m_owner >= 0) || m_ov));
        if (m_ov) begin
            check("mem_in_addr", 64'(mem_in_addr), 64'(m_oa));
            check("mem_in_data", 64'(mem_in_data), 64'(m_od));
        end
`ifdef ARB_STATS_EN
        check("stat0_count", 64'(stat0_count), 64'(m_st0));
        check("stat1_count", 64'(stat1_count), 64'(m_st1));
`endif
        obs_r1  = req1_ready;
        obs_hs0 = v0 && req0_ready;
        @(posedge clk);
        model_edge();
        #1;
        if (m_acc0) begin left0--; a0 = $urandom; d0 = $urandom; end
        if (m_acc1) begin left1--; a1 = $urandom; d1 = $urandom; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'(2'b00));
        check({tag, "_rdy0"}, 64'(req0_ready), 64'(1'b0));
        check({tag, "_rdy1"}, 64'(req1_ready), 64'(1'b0));
        check({tag, "_valid"}, 64'(mem_in_valid), 64'(1'b0));
        check({tag, "_addr"}, 64'(mem_in_addr), 64'(0));
        check({tag, "_data"}, 64'(mem_in_data), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(1'b0));
    endtask

    // Called at posedge+1: pulses reset between edges and resumes at the next posedge+1
    task automatic do_reset();
        left0 = 0; left1 = 0; v0 = 1'b0; v1 = 1'b0;
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] w1a, w2a;
        logic [DW-1:0] w1d, w2d;
        int   n_hs;
        logic idle_seen;

        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; mr = 1'b1;
        a0 = '0; d0 = '0; a1 = '0; d1 = '0;
        left0 = 0; left1 = 0;
        obs_r1 = 1'b0; obs_hs0 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("rst");

        // Transfer counts: 3 from req0, 7 from req1
        a0 = 32'h1000; d0 = 32'h1; a1 = 32'h2000; d1 = 32'h2;
        left0 = 3; left1 = 7; mr = 1'b1;
        run(30);
`ifdef ARB_STATS_EN
        check("stats_cnt0", 64'(stat0_count), 64'(3));
        check("stats_cnt1", 64'(stat1_count), 64'(7));
`endif
        do_reset();
        check_reset_state("rst2");
`ifdef ARB_STATS_EN
        check("stats_clr0", 64'(stat0_count), 64'(0));
        check("stats_clr1", 64'(stat1_count), 64'(0));
`endif

        // Single requester
        a0 = 32'h10; d0 = 32'hA5; left0 = 1; mr = 1'b1;
        cycle();
        check("single_grant", 64'(grant), 64'(2'b01));
        cycle();
        check("single_valid", 64'(mem_in_valid), 64'(1'b1));
        check("single_addr", 64'(mem_in_addr), 64'(32'h10));
        check("single_data", 64'(mem_in_data), 64'(32'hA5));
        cycle();
        check("single_valid_drop", 64'(mem_in_valid), 64'(1'b0));
        check("single_busy_drop", 64'(busy), 64'(1'b0));

        // Tie after reset goes to req0, then req1, then req0 again
        do_reset();
        left0 = 1; left1 = 1;
        cycle();
        check("tie_first", 64'(grant), 64'(2'b01));
        cycle();
        cycle();
        check("tie_idle", 64'(grant), 64'(2'b00));
        cycle();
        check("tie_second", 64'(grant), 64'(2'b10));
        run(3);
        left0 = 1; left1 = 1;
        cycle();
        check("tie_third", 64'(grant), 64'(2'b01));
        run(8);

        // Starvation bound: req0 streams while req1 waits
        left0 = 100; left1 = 3;
        cycle();
        check("hold_start", 64'(grant), 64'(2'b01));
        n_hs = 0;
        idle_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_hs += int'(obs_hs0);
            if (grant == 2'b10) break;
            if (grant == 2'b00) idle_seen = 1'b1;
        end
        check("hold_switch", 64'(grant), 64'(2'b10));
        check("hold_count", 64'(n_hs), 64'(MAX_HOLD));
        check("hold_no_idle", 64'(idle_seen), 64'(1'b0));
        left0 = 2;
        run(20);

        // Backpressure on the memory side
        mr = 1'b0; left1 = 2;
        cycle();
        w1a = a1; w1d = d1;
        cycle();
        check("bp_load_addr", 64'(mem_in_addr), 64'(w1a));
        w2a = a1; w2d = d1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_ready_low", 64'(obs_r1), 64'(1'b0));
            check("bp_addr_hold", 64'(mem_in_addr), 64'(w1a));
            check("bp_data_hold", 64'(mem_in_data), 64'(w1d));
        end
        mr = 1'b1;
        cycle();
        check("bp_ready_high", 64'(obs_r1), 64'(1'b1));
        check("bp_new_valid", 64'(mem_in_valid), 64'(1'b1));
        check("bp_new_addr", 64'(mem_in_addr), 64'(w2a));
        check("bp_new_data", 64'(mem_in_data), 64'(w2d));
        run(5);

        // Asynchronous reset with a word pending and req1 owning the port
        mr = 1'b0; left1 = 3;
        cycle();
        cycle();
        check("ar_pre_grant", 64'(grant), 64'(2'b10));
        check("ar_pre_valid", 64'(mem_in_valid), 64'(1'b1));
        #2 reset = 1'b1;
        #1;
        check_reset_state("ar");
        model_reset();
        left0 = 0; left1 = 0; v0 = 1'b0; v1 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        mr = 1'b1; a1 = 32'h44; d1 = 32'h55; left1 = 1;
        cycle();
        check("ar_fresh_grant", 64'(grant), 64'(2'b10));
        cycle();
        check("ar_fresh_valid", 64'(mem_in_valid), 64'(1'b1));
        check("ar_fresh_addr", 64'(mem_in_addr), 64'(32'h44));
        check("ar_fresh_data", 64'(mem_in_data), 64'(32'h55));
        run(3);

        // Randomized traffic with random memory backpressure
        for (int i = 0; i < 400; i++) begin
            if (left0 == 0 && $urandom_range(0, 3) == 0) begin
                left0 = $urandom_range(1, 7); a0 = $urandom; d0 = $urandom;
            end
            if (left1 == 0 && $urandom_range(0, 3) == 0) begin
                left1 = $urandom_range(1, 7); a1 = $urandom; d1 = $urandom;
            end
            mr = ($urandom_range(0, 3) != 0);
            cycle();
        end
        left0 = 0; left1 = 0; mr = 1'b1;
        run(4);
        check("final_idle_grant", 64'(grant), 64'(2'b00));
        check("final_idle_busy", 64'(busy), 64'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
